// File: rtl/id_ex_stage.sv
// id_ex_stage
// ---------------------------------------------------------------------------
// ID/EX pipeline register of a 5-stage MIPS pipeline. It sits directly
// upstream of ALU control and the ALU. It also owns the load-use hazard
// detector, bubble insertion, flush and hold handling, and a saturating
// debug counter of hazard bubbles.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rs/rt/rd_addr      register address fields from ID
//   id_rs/rt_data, id_imm register-file operands and sign-extended immediate
//   id_funct, id_alu_op   funct field and ALU op class (0 add, 1 sub, 2 R)
//   id_ctrl               {branch, mem_to_reg, reg_write, mem_write,
//                          mem_read, alu_src, reg_dst}
//   ex_stall              downstream cannot advance: hold everything
//   flush                 squash the instruction entering EX
//   ex_* / ctrl_*         registered copies presented to EX and ALU control
//   stall_upstream        combinational: hold PC and IF/ID this cycle
//   bubble_cnt            saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic [6:0]        id_ctrl,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [1:0]        ctrl_alu_op_id_ex,
  output logic [5:0]        ctrl_funct,
  output logic [6:0]        ex_ctrl,
  output logic [REG_AW-1:0] ex_rs_addr,
  output logic [REG_AW-1:0] ex_rt_addr,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              stall_upstream,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Bit position of mem_read inside the control bundle.
  localparam int MEM_READ_BIT = 2;

  logic              valid_q,  valid_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [5:0]        funct_q,  funct_d;
  logic [6:0]        ctrl_q,   ctrl_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic load_use;

  // Conservative: rt is compared even for instructions that do not read it.
  // $0 never creates a dependency since it is hard-wired to zero.
  assign load_use = id_valid & valid_q & ctrl_q[MEM_READ_BIT]
                  & (rt_addr_q != '0)
                  & ((rt_addr_q == id_rs_addr) | (rt_addr_q == id_rt_addr));

  // A flushed slot is replaced anyway, so a hazard against it is irrelevant.
  assign stall_upstream = ex_stall | (load_use & ~flush);

  always_comb begin
    valid_d   = valid_q;
    alu_op_d  = alu_op_q;
    funct_d   = funct_q;
    ctrl_d    = ctrl_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;

    if (ex_stall) begin
      // hold: defaults already keep every register
    end else if (flush || load_use) begin
      // Bubble: all-zero slot. alu_op 0 decodes to ADD and ctrl 0 writes
      // nothing, so the bubble has no architectural effect.
      valid_d   = 1'b0;
      alu_op_d  = '0;
      funct_d   = '0;
      ctrl_d    = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      // Only hazard bubbles are counted; flush has priority over load_use.
      if (!flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d   = id_valid;
      alu_op_d  = id_alu_op;
      funct_d   = id_funct;
      // Raw fields pass through for a non-valid slot, but control is
      // forced to zero so it can never write state.
      ctrl_d    = id_valid ? id_ctrl : 7'd0;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      rd_addr_d = id_rd_addr;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_op_q  <= '0;
      funct_q   <= '0;
      ctrl_q    <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      funct_q   <= funct_d;
      ctrl_q    <= ctrl_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid          = valid_q;
  assign ctrl_alu_op_id_ex = alu_op_q;
  assign ctrl_funct        = funct_q;
  assign ex_ctrl           = ctrl_q;
  assign ex_rs_addr        = rs_addr_q;
  assign ex_rt_addr        = rt_addr_q;
  assign ex_rd_addr        = rd_addr_q;
  assign ex_rs_data        = rs_data_q;
  assign ex_rt_data        = rt_data_q;
  assign ex_imm            = imm_q;
  assign bubble_cnt        = cnt_q;

endmodule
